// File: rtl/pipelined_addsub.sv
// Two-stage pipelined WIDTH-bit adder/subtractor with valid/ready handshakes.
// Define PIPELINED_ADDSUB_SAT_EN to saturate the result on signed overflow.
module pipelined_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);
    localparam int LO_W = WIDTH / 2;
    localparam int HI_W = WIDTH - LO_W;

    logic [WIDTH-1:0] w_b_eff;
    logic             w_cin_eff;
    logic [LO_W:0]    w_lo;
    logic             w_adv2;
    logic             w_in_xfer;

    logic             r_v1;
    logic [LO_W-1:0]  r_lo_sum;
    logic             r_c_lo;
    logic [HI_W-1:0]  r_a_hi;
    logic [HI_W-1:0]  r_b_hi;

    logic [HI_W:0]    w_hi;
    logic [WIDTH-1:0] w_raw;
    logic [WIDTH-1:0] w_res;
    logic             w_ovf;

    logic             r_v2;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic             r_ovf;
    logic             r_zero;
    logic             r_neg;

    // Subtract is a + ~b + 1, so the forced carry-in replaces cin
    assign w_b_eff   = sub ? ~b : b;
    assign w_cin_eff = sub ? 1'b1 : cin;
    assign w_lo      = {1'b0, a[LO_W-1:0]}
                     + {1'b0, w_b_eff[LO_W-1:0]}
                     + {{LO_W{1'b0}}, w_cin_eff};

    assign w_adv2    = r_v1 && (!r_v2 || out_ready);
    assign in_ready  = !r_v1 || w_adv2;
    assign w_in_xfer = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1     <= 1'b0;
            r_lo_sum <= '0;
            r_c_lo   <= 1'b0;
            r_a_hi   <= '0;
            r_b_hi   <= '0;
        end else if (w_in_xfer) begin
            r_v1     <= 1'b1;
            r_lo_sum <= w_lo[LO_W-1:0];
            r_c_lo   <= w_lo[LO_W];
            r_a_hi   <= a[WIDTH-1:LO_W];
            r_b_hi   <= w_b_eff[WIDTH-1:LO_W];
        end else if (w_adv2) begin
            r_v1     <= 1'b0;
        end
    end

    // Sign bits of a and b_eff are the top bits of the latched upper halves
    assign w_hi  = {1'b0, r_a_hi} + {1'b0, r_b_hi} + {{HI_W{1'b0}}, r_c_lo};
    assign w_raw = {w_hi[HI_W-1:0], r_lo_sum};
    assign w_ovf = (r_a_hi[HI_W-1] == r_b_hi[HI_W-1])
                && (w_raw[WIDTH-1] != r_a_hi[HI_W-1]);

`ifdef PIPELINED_ADDSUB_SAT_EN
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    always_comb begin
        w_res = w_raw;
        if (w_ovf) begin
            w_res = r_a_hi[HI_W-1] ? MIN_NEG : MAX_POS;
        end
    end
`else
    assign w_res = w_raw;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v2     <= 1'b0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
            r_neg    <= 1'b0;
        end else if (w_adv2) begin
            r_v2     <= 1'b1;
            r_result <= w_res;
            r_carry  <= w_hi[HI_W];
            r_ovf    <= w_ovf;
            r_zero   <= (w_res == '0);
            r_neg    <= w_raw[WIDTH-1];
        end else if (out_ready) begin
            r_v2     <= 1'b0;
        end
    end

    assign out_valid = r_v2;
    assign result    = r_result;
    assign carry     = r_carry;
    assign ovf       = r_ovf;
    assign zero      = r_zero;
    assign neg       = r_neg;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub (WIDTH=8).
// Honours PIPELINED_ADDSUB_SAT_EN when the DUT is built with it.
module tb_pipelined_addsub;
    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] res;
        logic         carry;
        logic         ovf;
        logic         zero;
        logic         neg;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         sub = 1'b0;
    logic         cin = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] result;
    logic         carry;
    logic         ovf;
    logic         zero;
    logic         neg;

    pipelined_addsub #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .carry(carry), .ovf(ovf),
        .zero(zero), .neg(neg)
    );

    always #5 clk = ~clk;

    exp_t         sb_q[$];
    int           cyc_q[$];
    logic [W-1:0] got_q[$];
    int           n_vec = 0;
    int           n_err = 0;
    int           cyc = 0;
    bit           chk_lat = 1'b0;
    exp_t         last_out;
    exp_t         m_exp;
    int           m_t;

    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                   input logic s, input logic c);
        exp_t         e;
        logic [W:0]   full;
        logic [W-1:0] be;
        logic         ci;
        be   = s ? ~bv : bv;
        ci   = s ? 1'b1 : c;
        full = {1'b0, av} + {1'b0, be} + {{W{1'b0}}, ci};
        e.carry = full[W];
        e.ovf   = (av[W-1] == be[W-1]) && (full[W-1] != av[W-1]);
        e.neg   = full[W-1];
        e.res   = full[W-1:0];
`ifdef PIPELINED_ADDSUB_SAT_EN
        if (e.ovf) e.res = av[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
        e.zero  = (e.res == '0);
        return e;
    endfunction

    // Scoreboard: push on input transfer, pop and compare on output transfer
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            sb_q.delete();
            cyc_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_vec++;
                if (sb_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_beat: got result=%h, required no beat", result);
                end else begin
                    m_exp    = sb_q.pop_front();
                    m_t      = cyc_q.pop_front();
                    last_out = {result, carry, ovf, zero, neg};
                    got_q.push_back(result);
                    if (last_out !== m_exp) begin
                        n_err++;
                        $display("FAIL result_flags: got %h/c%b/o%b/z%b/n%b required %h/c%b/o%b/z%b/n%b",
                                 last_out.res, last_out.carry, last_out.ovf, last_out.zero, last_out.neg,
                                 m_exp.res, m_exp.carry, m_exp.ovf, m_exp.zero, m_exp.neg);
                    end
                    if (chk_lat) begin
                        n_vec++;
                        if (cyc - m_t !== 2) begin
                            n_err++;
                            $display("FAIL latency: got %0d required 2", cyc - m_t);
                        end
                    end
                end
            end
            if (in_valid && in_ready) begin
                sb_q.push_back(model(a, b, sub, cin));
                cyc_q.push_back(cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic s, input logic c);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        a = av; b = bv; sub = s; cin = c;
        for (int t = 0; t < 40 && !ok; t++) begin
            @(negedge clk);
            ok = in_ready;
            tick();
        end
        in_valid = 1'b0;
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL drive_timeout: in_ready got 0 required 1");
        end
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 40 && (sb_q.size() != 0 || out_valid); t++) tick();
        n_vec++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d outstanding required 0", sb_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL reset_hs: got ov=%b ir=%b required ov=0 ir=1", out_valid, in_ready);
        end
        n_vec++;
        if ({result, carry, ovf, zero, neg} !== '0) begin
            n_err++;
            $display("FAIL reset_out: got %h/c%b/o%b/z%b/n%b required all 0",
                     result, carry, ovf, zero, neg);
        end
        tick();
    endtask

    task automatic test_add();
        chk_lat = 1'b1;
        drive(8'h7F, 8'h01, 1'b0, 1'b0);
        wait_drain();
        n_vec++;
`ifdef PIPELINED_ADDSUB_SAT_EN
        if (last_out !== {8'h7F, 1'b0, 1'b1, 1'b0, 1'b1}) begin
`else
        if (last_out !== {8'h80, 1'b0, 1'b1, 1'b0, 1'b1}) begin
`endif
            n_err++;
            $display("FAIL add_ovf: got %h/c%b/o%b/z%b/n%b", last_out.res,
                     last_out.carry, last_out.ovf, last_out.zero, last_out.neg);
        end
        drive(8'hFF, 8'h00, 1'b0, 1'b1);
        wait_drain();
        n_vec++;
        if (last_out !== {8'h00, 1'b1, 1'b0, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL add_cin: got %h/c%b/o%b/z%b/n%b required 00/c1/o0/z1/n0",
                     last_out.res, last_out.carry, last_out.ovf, last_out.zero, last_out.neg);
        end
    endtask

    task automatic test_sub();
        chk_lat = 1'b1;
        drive(8'h05, 8'h05, 1'b1, 1'b1);
        wait_drain();
        n_vec++;
        if (last_out !== {8'h00, 1'b1, 1'b0, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL sub_eq: got %h/c%b/o%b/z%b/n%b required 00/c1/o0/z1/n0",
                     last_out.res, last_out.carry, last_out.ovf, last_out.zero, last_out.neg);
        end
        drive(8'h00, 8'h01, 1'b1, 1'b0);
        wait_drain();
        n_vec++;
        if (last_out !== {8'hFF, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL sub_borrow: got %h/c%b/o%b/z%b/n%b required ff/c0/o0/z0/n1",
                     last_out.res, last_out.carry, last_out.ovf, last_out.zero, last_out.neg);
        end
        drive(8'h80, 8'h01, 1'b1, 1'b0);
        wait_drain();
        n_vec++;
`ifdef PIPELINED_ADDSUB_SAT_EN
        if (last_out !== {8'h80, 1'b1, 1'b1, 1'b0, 1'b0}) begin
`else
        if (last_out !== {8'h7F, 1'b1, 1'b1, 1'b0, 1'b0}) begin
`endif
            n_err++;
            $display("FAIL sub_ovf: got %h/c%b/o%b/z%b/n%b", last_out.res,
                     last_out.carry, last_out.ovf, last_out.zero, last_out.neg);
        end
    endtask

    task automatic test_backpressure();
        int           idx;
        int           stall;
        int           start;
        bit           saw_low;
        bit           prev_st;
        logic [W-1:0] held;
        idx = 0; stall = 0; saw_low = 0; prev_st = 0; held = '0;
        start = got_q.size();
        chk_lat = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (idx < 5) begin
                in_valid = 1'b1;
                a = W'(idx + 1); b = W'(idx + 1);
                sub = 1'b0; cin = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
            out_ready = (stall >= 4);
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            if (in_valid && !in_ready) begin
                saw_low = 1'b1;
                n_vec++;
                if (sb_q.size() != 2) begin
                    n_err++;
                    $display("FAIL held_beats: got %0d required 2", sb_q.size());
                end
            end
            if (out_valid && !out_ready) begin
                if (prev_st) begin
                    n_vec++;
                    if (result !== held) begin
                        n_err++;
                        $display("FAIL stall_stable: got %h required %h", result, held);
                    end
                end
                held = result;
                prev_st = 1'b1;
                stall++;
            end else begin
                prev_st = 1'b0;
            end
            tick();
            if (idx == 5 && got_q.size() - start == 5) break;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_drain();
        n_vec++;
        if (!saw_low) begin
            n_err++;
            $display("FAIL in_ready_drop: got never low required low");
        end
        n_vec++;
        if (got_q.size() - start != 5) begin
            n_err++;
            $display("FAIL bp_count: got %0d required 5", got_q.size() - start);
        end else begin
            for (int k = 0; k < 5; k++) begin
                n_vec++;
                if (got_q[start + k] !== W'(2 * (k + 1))) begin
                    n_err++;
                    $display("FAIL bp_order[%0d]: got %h required %h", k,
                             got_q[start + k], W'(2 * (k + 1)));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int start;
        start = got_q.size();
        chk_lat = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            a = W'($urandom); b = W'($urandom);
            sub = 1'($urandom); cin = 1'($urandom);
            @(negedge clk);
            n_vec++;
            if (in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_ready[%0d]: got %b required 1", i, in_ready);
            end
            tick();
        end
        in_valid = 1'b0;
        wait_drain();
        n_vec++;
        if (got_q.size() - start != 16) begin
            n_err++;
            $display("FAIL b2b_count: got %0d required 16", got_q.size() - start);
        end
    endtask

    task automatic test_reset_midstream();
        bit seen;
        seen = 1'b0;
        chk_lat = 1'b0;
        out_ready = 1'b0;
        drive(8'h11, 8'h22, 1'b0, 1'b0);
        drive(8'h33, 8'h44, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({out_valid, in_ready} !== 2'b01 || result !== '0) begin
            n_err++;
            $display("FAIL mid_reset: got ov=%b ir=%b res=%h required ov=0 ir=1 res=00",
                     out_valid, in_ready, result);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
            tick();
        end
        n_vec++;
        if (seen) begin
            n_err++;
            $display("FAIL stale_beat: got out_valid=1 required 0");
        end
        chk_lat = 1'b1;
        drive(8'h05, 8'h06, 1'b0, 1'b1);
        wait_drain();
        n_vec++;
        if (last_out.res !== 8'h0C) begin
            n_err++;
            $display("FAIL post_reset: got %h required 0c", last_out.res);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_backpressure();
        test_back_to_back();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
